// File: rtl/control_fsm_seq_if.sv
// Host/datapath handshake bundle for the control_fsm_seq sequencer.
// The master side drives start/abort/run_len; the slave side returns the controls and status.
interface control_fsm_seq_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] run_len;
    logic             reset_out;
    logic             load;
    logic             enable;
    logic             busy;
    logic             done;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, abort, run_len,
        input  reset_out, load, enable, busy, done, state, cycles
    );

    modport slave (
        input  start, abort, run_len,
        output reset_out, load, enable, busy, done, state, cycles
    );
endinterface

// File: rtl/control_fsm_seq.sv
// Sequencer driving a datapath through clear, load and an enable window of run_len cycles,
// finishing with a one-cycle done strobe; abortable, with busy/state/cycle-count readout.
module control_fsm_seq #(
    parameter int CNT_W       = 8,
    parameter int RST_CYCLES  = 2,
    parameter int LOAD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    control_fsm_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_INIT  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_CYCLES - 1);

    state_t           state_q;
    state_t           nxt_state;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cycles_q;

    // Abort outranks every other exit from the busy states, including terminal count.
    always_comb begin
        nxt_state = ST_IDLE;
        case (state_q)
            ST_IDLE:  nxt_state = bus.start ? ST_RESET : ST_IDLE;
            ST_RESET: begin
                if (bus.abort)                nxt_state = ST_IDLE;
                else if (phase_q == '0)       nxt_state = ST_LOAD;
                else                          nxt_state = ST_RESET;
            end
            ST_LOAD: begin
                if (bus.abort)                nxt_state = ST_IDLE;
                else if (phase_q != '0)       nxt_state = ST_LOAD;
                else if (len_q != '0)         nxt_state = ST_RUN;
                else                          nxt_state = ST_DONE;
            end
            ST_RUN: begin
                if (bus.abort)                nxt_state = ST_IDLE;
                else if (cycles_q == len_q - ONE) nxt_state = ST_DONE;
                else                          nxt_state = ST_RUN;
            end
            ST_DONE:  nxt_state = ST_IDLE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            len_q         <= '0;
            cycles_q      <= '0;
            bus.reset_out <= 1'b0;
            bus.load      <= 1'b0;
            bus.enable    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state_q <= nxt_state;

            if (state_q == ST_IDLE && bus.start) begin
                len_q    <= bus.run_len;
                cycles_q <= '0;
            end else if (state_q == ST_RUN) begin
                cycles_q <= cycles_q + ONE;
            end

            // Phase counter reloads on entry to a timed state and counts down while it stays.
            case (nxt_state)
                ST_RESET: phase_q <= (state_q == ST_RESET) ? phase_q - ONE : RST_INIT;
                ST_LOAD:  phase_q <= (state_q == ST_LOAD)  ? phase_q - ONE : LOAD_INIT;
                default:  phase_q <= phase_q;
            endcase

            bus.reset_out <= (nxt_state == ST_RESET);
            bus.load      <= (nxt_state == ST_LOAD);
            bus.enable    <= (nxt_state == ST_RUN);
            bus.busy      <= (nxt_state == ST_RESET) || (nxt_state == ST_LOAD) || (nxt_state == ST_RUN);
            bus.done      <= (nxt_state == ST_DONE);
        end
    end

    assign bus.state  = state_q;
    assign bus.cycles = cycles_q;

endmodule

// File: tb/tb_control_fsm_seq.sv
// Directed bench for control_fsm_seq: default-timing instance plus a RST_CYCLES=4/LOAD_CYCLES=3 one.
module tb_control_fsm_seq;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    control_fsm_seq_if #(.CNT_W(8)) a_if ();
    control_fsm_seq_if #(.CNT_W(8)) b_if ();

    control_fsm_seq #(.CNT_W(8), .RST_CYCLES(2), .LOAD_CYCLES(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    control_fsm_seq #(.CNT_W(8), .RST_CYCLES(4), .LOAD_CYCLES(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {reset_out, load, enable, busy, done, state}
    function automatic logic [7:0] expCtl(input logic [2:0] st);
        return {st == 3'd1, st == 3'd2, st == 3'd3, (st >= 3'd1 && st <= 3'd3), st == 3'd4, st};
    endfunction

    function automatic logic [7:0] getCtl(input int sel);
        if (sel == 0)
            return {a_if.reset_out, a_if.load, a_if.enable, a_if.busy, a_if.done, a_if.state};
        return {b_if.reset_out, b_if.load, b_if.enable, b_if.busy, b_if.done, b_if.state};
    endfunction

    function automatic logic [7:0] getCycles(input int sel);
        return (sel == 0) ? a_if.cycles : b_if.cycles;
    endfunction

    function automatic logic [2:0] expState(input int i, input int r, input int l, input int len);
        if (i < r)                 return 3'd1;
        else if (i < r + l)        return 3'd2;
        else if (i < r + l + len)  return 3'd3;
        else if (i == r + l + len) return 3'd4;
        return 3'd0;
    endfunction

    // One-cycle start pulse, then every cycle through DONE and back to IDLE is checked.
    task automatic applyStimulus(input int sel, input string tag, input int r, input int l, input int len);
        int total;
        total = r + l + len + 2;
        if (sel == 0) begin a_if.start = 1'b1; a_if.run_len = 8'(len); end
        else          begin b_if.start = 1'b1; b_if.run_len = 8'(len); end
        step();
        if (sel == 0) a_if.start = 1'b0; else b_if.start = 1'b0;
        for (int i = 0; i < total; i++) begin
            checkOutput($sformatf("%s_cyc%0d", tag, i), getCtl(sel), expCtl(expState(i, r, l, len)));
            if (i < total - 1) step();
        end
        checkOutput({tag, "_cycles"}, getCycles(sel), len);
    endtask

    initial begin
        int enables;
        logic [2:0] pat [7];
        pat = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0};
        checks = 0;
        errors = 0;
        reset = 1'b1;
        a_if.start = 1'b0; a_if.abort = 1'b0; a_if.run_len = '0;
        b_if.start = 1'b0; b_if.abort = 1'b0; b_if.run_len = '0;

        #2;
        checkOutput("por_ctl_a", getCtl(0), 8'h00);
        checkOutput("por_ctl_b", getCtl(1), 8'h00);
        step();
        step();
        reset = 1'b0;
        step();
        checkOutput("idle_after_release", getCtl(0), 8'h00);

        // Async reset mid-RUN
        a_if.start = 1'b1; a_if.run_len = 8'd5;
        step();
        a_if.start = 1'b0;
        step(); step(); step(); step();
        checkOutput("pre_reset_run", getCtl(0), expCtl(3'd3));
        checkOutput("pre_reset_cycles", getCycles(0), 8'd1);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_ctl", getCtl(0), 8'h00);
        checkOutput("async_reset_cycles", getCycles(0), 8'd0);
        step();
        reset = 1'b0;
        step(); step();
        checkOutput("post_reset_idle", getCtl(0), 8'h00);

        // Abort ignored in IDLE
        a_if.abort = 1'b1;
        step();
        a_if.abort = 1'b0;
        checkOutput("abort_in_idle", getCtl(0), 8'h00);

        applyStimulus(0, "run5", 2, 1, 5);
        applyStimulus(0, "run0", 2, 1, 0);

        // Abort on the third enable cycle
        a_if.start = 1'b1; a_if.run_len = 8'd10;
        step();
        a_if.start = 1'b0;
        step(); step(); step(); step(); step();
        checkOutput("abort_pre_ctl", getCtl(0), expCtl(3'd3));
        checkOutput("abort_pre_cycles", getCycles(0), 8'd2);
        a_if.abort = 1'b1;
        step();
        a_if.abort = 1'b0;
        checkOutput("abort_ctl", getCtl(0), 8'h00);
        checkOutput("abort_cycles", getCycles(0), 8'd3);
        step();
        checkOutput("abort_no_done", getCtl(0), 8'h00);

        // start held high: back-to-back sequences with one IDLE cycle between
        a_if.start = 1'b1; a_if.run_len = 8'd2;
        step();
        for (int k = 0; k < 14; k++) begin
            checkOutput($sformatf("b2b_cyc%0d", k), getCtl(0), expCtl(pat[k % 7]));
            if (k == 12) a_if.start = 1'b0;
            step();
        end
        checkOutput("b2b_stop", getCtl(0), 8'h00);
        checkOutput("b2b_cycles", getCycles(0), 8'd2);

        // run_len=255, changed to 1 while in LOAD
        a_if.start = 1'b1; a_if.run_len = 8'd255;
        step();
        a_if.start = 1'b0;
        step(); step();
        checkOutput("long_in_load", getCtl(0), expCtl(3'd2));
        a_if.run_len = 8'd1;
        enables = 0;
        for (int k = 0; k < 300 && a_if.done !== 1'b1; k++) begin
            step();
            if (a_if.enable === 1'b1) enables++;
        end
        checkOutput("long_done", getCtl(0), expCtl(3'd4));
        checkOutput("long_enables", enables, 255);
        checkOutput("long_cycles", getCycles(0), 8'd255);
        step();
        checkOutput("long_idle", getCtl(0), 8'h00);

        applyStimulus(1, "wide", 4, 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_fsm_seq.md
Name: control_fsm_seq

Overview:
Parametrised sequencer that drives a loadable counter/datapath through a fixed command sequence: clear pulse, load pulse, then an enable window of programmable length. It ends with a one-cycle done strobe. It adds programmable pulse widths, a run-length counter, abort, busy/done status and a state readout. It sits between a host start/abort interface and the datapath's reset_out/load/enable controls.

Parameters:
CNT_W, 8, width of run_len, cycles and the internal phase counter
RST_CYCLES, 2, number of cycles reset_out is held high (legal range 1..2^CNT_W-1)
LOAD_CYCLES, 1, number of cycles load is held high (legal range 1..2^CNT_W-1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level; sampled only in IDLE
abort  input  1  level; sampled in RESET/LOAD/RUN
run_len  input  CNT_W  number of enable cycles; latched on accepted start
reset_out  output  1  datapath clear, high in RESET state
load  output  1  datapath load, high in LOAD state
enable  output  1  datapath count enable, high in RUN state
busy  output  1  high in RESET, LOAD, RUN
done  output  1  one-cycle strobe, high in DONE state
state  output  3  current state encoding
cycles  output  CNT_W  count of enable cycles in current/last run

Behaviour:
- One clock; reset is asynchronous and active-high. Port names are clk and reset.
- While reset is high: state=IDLE and all outputs are 0 immediately, without waiting for a clock edge. This includes cycles and the latched length.
- State encoding: IDLE=0, RESET=1, LOAD=2, RUN=3, DONE=4. Codes 5-7 are illegal; any clock edge in an illegal state moves to IDLE.
- All outputs are registered Moore decodes of the state:
  - reset_out=(RESET), load=(LOAD), enable=(RUN), done=(DONE), busy=(RESET|LOAD|RUN).
  - An input sampled at edge N takes effect on the outputs from edge N, i.e. visible in the cycle after sampling.
- IDLE:
  - start=1 -> go to RESET; latch len_q=run_len; clear cycles to 0; load the phase counter.
  - start=0 -> stay in IDLE.
- RESET: held for exactly RST_CYCLES cycles, then go to LOAD.
- LOAD: held for exactly LOAD_CYCLES cycles, then go to RUN if len_q!=0, otherwise go to DONE.
- RUN:
  - cycles increments by 1 on every RUN cycle.
  - When cycles==len_q-1 at an edge, go to DONE. This gives exactly len_q enable cycles.
  - Maximum run is 2^CNT_W-1, so cycles never wraps.
- DONE: lasts 1 cycle, then IDLE unconditionally. start is ignored in DONE.
- abort:
  - In RESET/LOAD/RUN, abort=1 -> IDLE at the next edge. abort has priority over every other transition, including the RUN->DONE terminal count. done is not pulsed.
  - An abort in RUN still counts that cycle's increment.
  - abort is ignored in IDLE and DONE.
- start while busy or in DONE: ignored, not queued. If start is still high on returning to IDLE, it is accepted at the next edge.
- run_len changes after acceptance: no effect on the current run; len_q holds the latched value.
- cycles holds its final value through DONE and IDLE until the next accepted start.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; no done strobe.

Test Plan:
- Assert reset during a RUN with run_len=5 -> in the same cycle reset_out/load/enable/busy/done=0, state=0, cycles=0, with no clock edge needed. After release the block stays in IDLE until start.
- Defaults, pulse start for 1 cycle with run_len=5 -> reset_out high 2 cycles, then load high 1 cycle, then enable high 5 cycles, then done high 1 cycle. busy high for 8 cycles, cycles=5, state back to 0.
- run_len=0 -> reset_out 2 cycles, load 1 cycle, done 1 cycle; enable never asserts; cycles=0.
- run_len=10, abort high during the 3rd enable cycle -> enable drops after that cycle, done never asserts, state=0, cycles=3.
- start held high continuously with run_len=2 -> back-to-back sequences, each 2+1+2+1 cycles. There is one IDLE cycle between the DONE of one sequence and the RESET of the next; start pulses while busy produce no extra sequence.
- run_len=255, change run_len to 1 during LOAD; separately, instantiate with RST_CYCLES=4, LOAD_CYCLES=3 and run_len=1 -> first case gives exactly 255 enable cycles and cycles=255. Second case gives reset_out 4 cycles, load 3 cycles, enable 1 cycle, done 1 cycle.
